// File: rtl/pow5_result_bcd_conv.sv
// pow5_result_bcd_conv
//   Sequential double-dabble (shift-add-3) binary-to-BCD converter for the
//   registered pow5 multiplier result. One input bit is consumed per clock,
//   and only one conversion is in flight at a time. The finished digits feed
//   the 7-segment display scanner.
//
//   Optional feature macro: BCD_BLANK_EN adds the bcd_blank_o leading-zero mask.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   bin_valid_i  bin_data_i holds a value to convert
//   bin_ready_o  converter is idle and can accept a value
//   bin_data_i   unsigned binary value, BIN_WIDTH bits
//   bcd_valid_o  bcd_data_o / bcd_ovf_o hold a finished result
//   bcd_ready_i  consumer takes the result
//   bcd_data_o   DIGITS BCD digits, digit 0 in bits [3:0]
//   bcd_ovf_o    value >= 10**DIGITS; bcd_data_o then holds value mod 10**DIGITS
//   bcd_blank_o  leading-zero blank mask (BCD_BLANK_EN only)
module pow5_result_bcd_conv #(
  parameter int unsigned BIN_WIDTH = 40,
  parameter int unsigned DIGITS    = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bin_valid_i,
  output logic                  bin_ready_o,
  input  logic [BIN_WIDTH-1:0]  bin_data_i,
  output logic                  bcd_valid_o,
  input  logic                  bcd_ready_i,
  output logic [4*DIGITS-1:0]   bcd_data_o,
  output logic                  bcd_ovf_o
`ifdef BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     bcd_blank_o
`endif
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]           state, state_nxt;
  logic [BIN_WIDTH-1:0] bin_sr, bin_sr_nxt;
  logic [BCD_W-1:0]     acc, acc_nxt, acc_adj, acc_shift;
  logic                 ovf_acc, ovf_acc_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 load_out;

  // Add-3 correction on every nibble in parallel, then shift the next binary bit in.
  always_comb begin
    acc_adj = acc;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (acc[4*k +: 4] >= 4'd5) acc_adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
    end
    acc_shift = {acc_adj[BCD_W-2:0], bin_sr[BIN_WIDTH-1]};
  end

  // Next-state and datapath control.
  always_comb begin
    state_nxt   = state;
    bin_sr_nxt  = bin_sr;
    acc_nxt     = acc;
    ovf_acc_nxt = ovf_acc;
    cnt_nxt     = cnt;
    load_out    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bin_valid_i && bin_ready_o) begin
          bin_sr_nxt  = bin_data_i;
          acc_nxt     = '0;
          ovf_acc_nxt = 1'b0;
          cnt_nxt     = '0;
          state_nxt   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bin_sr_nxt  = bin_sr << 1;
        acc_nxt     = acc_shift;
        // Any 1 leaving the top digit means the value no longer fits.
        ovf_acc_nxt = ovf_acc | acc_adj[BCD_W-1];
        cnt_nxt     = cnt + CNT_W'(1);
        if (cnt == CNT_W'(BIN_WIDTH - 1)) begin
          state_nxt = S_DONE;
          load_out  = 1'b1;
        end
      end
      S_DONE: begin
        if (bcd_ready_i) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank_nxt;

  // Digit k is blank when it and every higher digit are zero; digit 0 always shows.
  always_comb begin
    logic hz;
    hz        = 1'b1;
    blank_nxt = '0;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      hz           = hz & (acc_shift[4*k +: 4] == 4'd0);
      blank_nxt[k] = hz;
    end
    blank_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_blank_o <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else if (load_out) begin
      bcd_blank_o <= blank_nxt;
    end
  end
`endif

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      bin_sr      <= '0;
      acc         <= '0;
      ovf_acc     <= 1'b0;
      cnt         <= '0;
      bin_ready_o <= 1'b1;
      bcd_valid_o <= 1'b0;
      bcd_data_o  <= '0;
      bcd_ovf_o   <= 1'b0;
    end else begin
      state       <= state_nxt;
      bin_sr      <= bin_sr_nxt;
      acc         <= acc_nxt;
      ovf_acc     <= ovf_acc_nxt;
      cnt         <= cnt_nxt;
      bin_ready_o <= (state_nxt == S_IDLE);
      bcd_valid_o <= (state_nxt == S_DONE);
      if (load_out) begin
        bcd_data_o <= acc_shift;
        bcd_ovf_o  <= ovf_acc | acc_adj[BCD_W-1];
      end
    end
  end

endmodule

// File: tb/tb_pow5_result_bcd_conv.sv
// tb_pow5_result_bcd_conv
//   Directed and randomized bench for pow5_result_bcd_conv: a 40-bit/13-digit
//   instance and a 16-bit/4-digit instance, checked against a decimal model.
module tb_pow5_result_bcd_conv;

  logic clk;
  logic rst;

  // 40-bit / 13-digit instance
  logic        a_bin_valid, a_bin_ready, a_bcd_valid, a_bcd_ready, a_ovf;
  logic [39:0] a_bin_data;
  logic [51:0] a_bcd_data;
`ifdef BCD_BLANK_EN
  logic [12:0] a_blank;
`endif

  // 16-bit / 4-digit instance
  logic        b_bin_valid, b_bin_ready, b_bcd_valid, b_bcd_ready, b_ovf;
  logic [15:0] b_bin_data;
  logic [15:0] b_bcd_data;
`ifdef BCD_BLANK_EN
  logic [3:0]  b_blank;
`endif

  int tests = 0;
  int fails = 0;
  int out_cnt = 0;

  pow5_result_bcd_conv #(.BIN_WIDTH(40), .DIGITS(13)) dut_a (
    .clk(clk), .rst(rst),
    .bin_valid_i(a_bin_valid), .bin_ready_o(a_bin_ready), .bin_data_i(a_bin_data),
    .bcd_valid_o(a_bcd_valid), .bcd_ready_i(a_bcd_ready),
    .bcd_data_o(a_bcd_data), .bcd_ovf_o(a_ovf)
`ifdef BCD_BLANK_EN
    , .bcd_blank_o(a_blank)
`endif
  );

  pow5_result_bcd_conv #(.BIN_WIDTH(16), .DIGITS(4)) dut_b (
    .clk(clk), .rst(rst),
    .bin_valid_i(b_bin_valid), .bin_ready_o(b_bin_ready), .bin_data_i(b_bin_data),
    .bcd_valid_o(b_bcd_valid), .bcd_ready_i(b_bcd_ready),
    .bcd_data_o(b_bcd_data), .bcd_ovf_o(b_ovf)
`ifdef BCD_BLANK_EN
    , .bcd_blank_o(b_blank)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts output handshakes on the 13-digit instance.
  always @(posedge clk) begin
    if (!rst && a_bcd_valid && a_bcd_ready) out_cnt <= out_cnt + 1;
  end

  // Decimal reference model: digits of v mod 10**digits.
  function automatic logic [63:0] ref_bcd(input longint unsigned v, input int digits);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < digits; k++) begin
      r = r | (64'(v % 10) << (4 * k));
      v = v / 10;
    end
    return r;
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic ref_ovf(input longint unsigned v, input int digits);
    return v >= pow10(digits);
  endfunction

  // Digit k (k>=1) is blank when the displayed value is below 10**k.
  function automatic logic [63:0] ref_blank(input longint unsigned v, input int digits);
    logic [63:0]     r;
    longint unsigned vm;
    vm = v % pow10(digits);
    r  = '0;
    for (int k = 1; k < digits; k++) r[k] = (vm < pow10(k));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One conversion on the 13-digit instance; noisy drives ignored inputs during SHIFT.
  task automatic run_a(input longint unsigned v, input int hold, input bit noisy);
    int n;
    int lat;
    a_bin_data  = 40'(v);
    a_bin_valid = 1'b1;
    n = 0;
    while (!a_bin_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("a_accept_ready", 64'(a_bin_ready), 64'd1);
    @(posedge clk); #1;
    a_bin_valid = 1'b0;
    lat = 0;
    while (!a_bcd_valid && lat < 200) begin
      if (noisy) begin
        a_bcd_ready = 1'($urandom_range(0, 1));
        a_bin_valid = 1'($urandom_range(0, 1));
        a_bin_data  = 40'({$urandom, $urandom});
      end
      @(posedge clk); #1; lat++;
    end
    a_bcd_ready = 1'b0;
    a_bin_valid = 1'b0;
    chk("a_latency", 64'(lat), 64'd40);
    chk("a_data", 64'(a_bcd_data), ref_bcd(v, 13));
    chk("a_ovf", 64'(a_ovf), 64'(ref_ovf(v, 13)));
`ifdef BCD_BLANK_EN
    chk("a_blank", 64'(a_blank), ref_blank(v, 13));
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("a_hold_valid", 64'(a_bcd_valid), 64'd1);
      chk("a_hold_busy", 64'(a_bin_ready), 64'd0);
      chk("a_hold_data", 64'(a_bcd_data), ref_bcd(v, 13));
    end
    a_bcd_ready = 1'b1;
    @(posedge clk); #1;
    a_bcd_ready = 1'b0;
    chk("a_valid_drop", 64'(a_bcd_valid), 64'd0);
    chk("a_ready_back", 64'(a_bin_ready), 64'd1);
  endtask

  // One conversion on the 4-digit instance.
  task automatic run_b(input longint unsigned v);
    int lat;
    b_bin_data  = 16'(v);
    b_bin_valid = 1'b1;
    chk("b_accept_ready", 64'(b_bin_ready), 64'd1);
    @(posedge clk); #1;
    b_bin_valid = 1'b0;
    lat = 0;
    while (!b_bcd_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk("b_latency", 64'(lat), 64'd16);
    chk("b_data", 64'(b_bcd_data), ref_bcd(v, 4));
    chk("b_ovf", 64'(b_ovf), 64'(ref_ovf(v, 4)));
`ifdef BCD_BLANK_EN
    chk("b_blank", 64'(b_blank), ref_blank(v, 4));
`endif
    b_bcd_ready = 1'b1;
    @(posedge clk); #1;
    b_bcd_ready = 1'b0;
    chk("b_valid_drop", 64'(b_bcd_valid), 64'd0);
  endtask

  initial begin
    longint unsigned v;
    int base;
    rst = 1'b1;
    a_bin_valid = 1'b0; a_bcd_ready = 1'b0; a_bin_data = '0;
    b_bin_valid = 1'b0; b_bcd_ready = 1'b0; b_bin_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(a_bin_ready), 64'd1);
    chk("rst_valid", 64'(a_bcd_valid), 64'd0);
    chk("rst_data", 64'(a_bcd_data), 64'd0);
    chk("rst_ovf", 64'(a_ovf), 64'd0);
`ifdef BCD_BLANK_EN
    chk("rst_blank", 64'(a_blank), 64'h1FFE);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // T1/T2: zero and the largest pow5 result
    run_a(64'd0, 0, 1'b0);
    run_a(64'd1078203909375, 0, 1'b0);
    // T3: consumer stalls for 10 cycles
    run_a(64'd12345, 10, 1'b0);

    // T4: reset while the shift counter is at 20
    a_bin_data  = 40'hFF_FFFF_FFFF;
    a_bin_valid = 1'b1;
    @(posedge clk); #1;
    a_bin_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    chk("abort_ready", 64'(a_bin_ready), 64'd1);
    chk("abort_valid", 64'(a_bcd_valid), 64'd0);
    chk("abort_data", 64'(a_bcd_data), 64'd0);
    chk("abort_ovf", 64'(a_ovf), 64'd0);
`ifdef BCD_BLANK_EN
    chk("abort_blank", 64'(a_blank), 64'h1FFE);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_a(64'd99, 2, 1'b0);

    // T5: narrow instance, overflow boundary and random values
    run_b(64'd10000);
    run_b(64'd9999);
    run_b(64'd65535);
    for (int i = 0; i < 10; i++) run_b(longint'($urandom_range(0, 65535)));

    // T6: randomized back-to-back traffic with noise on ignored inputs
    base = out_cnt;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0:       v = longint'($urandom_range(0, 99999));
        1:       v = pow10(int'($urandom_range(0, 12))) - longint'($urandom_range(0, 1));
        default: v = {24'd0, 40'({$urandom, $urandom})};
      endcase
      run_a(v, int'($urandom_range(0, 3)), 1'b1);
    end
    @(posedge clk); #1;
    chk("out_count", 64'(out_cnt - base), 64'd200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
